// File: rtl/if_id_pkg.sv
// Shared definitions for the fetch/decode pipeline register.
// The skid entry is built only when IF_ID_SKID_EN is defined.
package if_id_pkg;

    localparam int ILEN      = 32;
    localparam int MAX_LANES = 4;
    localparam int MAX_XLEN  = 64;

    // addi x0,x0,0 -- what decode sees in empty or masked lanes
    localparam logic [ILEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } if_id_state_e;

    // Widest bundle any configuration can carry; narrower builds use the low bits.
    typedef struct packed {
        logic [MAX_XLEN-1:0]       pc;
        logic [MAX_LANES-1:0]      lane_valid;
        logic [MAX_LANES*ILEN-1:0] instr;
    } if_id_bundle_t;

endpackage

// File: rtl/if_id_entry.sv
// One bundle storage slot: loads on enable, clears synchronously to the bubble value.
module if_id_entry #(
    parameter int           W       = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    // Clear wins over load so a flush can never leave stale data behind.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_reg <= CLR_VAL;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/if_id_pipe.sv
// Fetch -> decode pipeline register with ready/valid on both sides.
// Define IF_ID_SKID_EN for a two-entry version whose in_ready comes from a flop;
// otherwise a single entry is used and in_ready depends combinationally on out_ready.
module if_id_pipe
    import if_id_pkg::*;
#(
    parameter int              LANES     = 1,
    parameter int              XLEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*ILEN-1:0] in_instr,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*ILEN-1:0] out_instr,
    output logic [XLEN-1:0]       out_pc,
    output logic [LANES-1:0]      out_lane_valid
);

    localparam int IW = LANES * ILEN;
    localparam int W  = XLEN + LANES + IW;
    // Empty entries hold exactly what the outputs must show as a bubble.
    localparam logic [W-1:0] BUBBLE = {{XLEN{1'b0}}, {LANES{1'b0}}, {LANES{NOP_INSTR}}};

    logic [IW-1:0]  cap_instr;
    logic [W-1:0]   cap_bundle;
    logic [W-1:0]   main_d;
    logic [W-1:0]   main_q;
    logic           main_load;
    logic           main_clr;
    logic           in_xfer;
    logic           out_xfer;
    if_id_state_e   state_reg;
    if_id_state_e   state_next;

    // Invalid lanes are replaced by the bubble instruction at capture time.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign cap_instr[gi*ILEN +: ILEN] =
                in_lane_valid[gi] ? in_instr[gi*ILEN +: ILEN] : NOP_INSTR;
        end
    endgenerate

    assign cap_bundle = {in_pc, in_lane_valid, cap_instr};
    assign out_valid  = (state_reg != EMPTY);
    assign {out_pc, out_lane_valid, out_instr} = main_q;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;

`ifdef IF_ID_SKID_EN
    logic         in_ready_reg;
    logic         skid_load;
    logic         skid_clr;
    logic [W-1:0] skid_q;

    // rst gates the flop so in_ready is low in the reset cycle and high right after.
    assign in_ready = in_ready_reg && !rst;

    // Next-state and entry control for the main + skid pair; flush overrides all.
    always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        main_clr   = 1'b0;
        skid_load  = 1'b0;
        skid_clr   = 1'b0;
        main_d     = cap_bundle;
        unique case (state_reg)
            EMPTY: begin
                if (in_xfer) begin
                    main_load  = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    skid_load  = 1'b1;
                    state_next = SKID;
                end else if (out_xfer) begin
                    main_clr   = 1'b1;
                    state_next = EMPTY;
                end
            end
            SKID: begin
                if (out_xfer) begin
                    main_d     = skid_q;
                    main_load  = 1'b1;
                    skid_clr   = 1'b1;
                    state_next = FULL;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next = EMPTY;
            main_clr   = 1'b1;
            skid_clr   = 1'b1;
        end
    end

    // State register plus the registered in_ready that breaks the out_ready path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != SKID);
        end
    end

    if_id_entry #(.W(W), .CLR_VAL(BUBBLE)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (skid_clr),
        .load (skid_load),
        .d    (cap_bundle),
        .q    (skid_q)
    );
`else
    assign in_ready = !rst && (!out_valid || out_ready);

    // Next-state and entry control for the single-entry register; flush overrides all.
    always_comb begin
        state_next = state_reg;
        main_load  = 1'b0;
        main_clr   = 1'b0;
        main_d     = cap_bundle;
        unique case (state_reg)
            EMPTY: begin
                if (in_xfer) begin
                    main_load  = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                end else if (out_xfer) begin
                    main_clr   = 1'b1;
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next = EMPTY;
            main_clr   = 1'b1;
        end
    end

    // State register for the single-entry build.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end
`endif

    if_id_entry #(.W(W), .CLR_VAL(BUBBLE)) u_main (
        .clk  (clk),
        .rst  (rst),
        .clr  (main_clr),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe (LANES=2). The reference model is a queue of
// bundles held by the stage; capacity is 2 with IF_ID_SKID_EN, otherwise 1.
module tb_if_id_pipe;
    import if_id_pkg::*;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
`ifdef IF_ID_SKID_EN
    localparam bit HAS_SKID = 1'b1;
`else
    localparam bit HAS_SKID = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [LANES*ILEN-1:0] in_instr = '0;
    logic [XLEN-1:0]       in_pc = '0;
    logic [LANES-1:0]      in_lane_valid = '0;
    logic                  flush = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [LANES*ILEN-1:0] out_instr;
    logic [XLEN-1:0]       out_pc;
    logic [LANES-1:0]      out_lane_valid;

    if_id_pipe #(.LANES(LANES), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .in_lane_valid  (in_lane_valid),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_lane_valid (out_lane_valid)
    );

    always #5 clk = ~clk;

    if_id_bundle_t sb[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    int  n_out  = 0;

    function automatic if_id_bundle_t mk(input logic [31:0] pc, input logic [63:0] ins,
                                         input logic [1:0] m);
        if_id_bundle_t b;
        b = '0;
        b.pc[XLEN-1:0] = pc;
        b.lane_valid[LANES-1:0] = m;
        for (int i = 0; i < LANES; i++)
            b.instr[i*ILEN +: ILEN] = m[i] ? ins[i*32 +: 32] : NOP_INSTR_DEFAULT;
        return b;
    endfunction

    // Stage accepts when it has room; without skid, room also appears when decode drains.
    function automatic logic exp_ready(input int occ, input logic ordy, input logic r);
        if (r) return 1'b0;
        if (HAS_SKID) return (occ < 2);
        return (occ == 0) || ordy;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares presented outputs with the model head and retires on transfer.
    if_id_bundle_t exp_b;
    int            occ_m;
    always @(negedge clk) begin
        if (mon_en) begin
            occ_m = sb.size();
            check("in_ready", {127'd0, in_ready}, {127'd0, exp_ready(occ_m, out_ready, rst)});
            check("out_valid", {127'd0, out_valid}, {127'd0, (occ_m > 0)});
            if (occ_m > 0) begin
                exp_b = sb[0];
                check("out_instr", {64'd0, out_instr}, {64'd0, exp_b.instr[63:0]});
                check("out_pc", {96'd0, out_pc}, {96'd0, exp_b.pc[XLEN-1:0]});
                check("out_lane_valid", {126'd0, out_lane_valid},
                      {126'd0, exp_b.lane_valid[LANES-1:0]});
                if (out_ready) begin
                    n_out++;
                    $display("OUT #%0d pc=%h instr=%h mask=%b", n_out, out_pc, out_instr,
                             out_lane_valid);
                    void'(sb.pop_front());
                end
            end else begin
                check("bubble_instr", {64'd0, out_instr}, {64'd0, {2{NOP_INSTR_DEFAULT}}});
                check("bubble_pc", {96'd0, out_pc}, 128'd0);
                check("bubble_mask", {126'd0, out_lane_valid}, 128'd0);
            end
        end
    end

    // One clock cycle of stimulus; the model updates at the edge the inputs apply to.
    task automatic step(input logic v, input logic [31:0] pc, input logic [63:0] ins,
                        input logic [1:0] m, input logic fl, input logic ordy,
                        input logic r, output logic acc);
        int occ;
        occ           = sb.size();
        in_valid      = v;
        in_pc         = pc;
        in_instr      = ins;
        in_lane_valid = m;
        flush         = fl;
        out_ready     = ordy;
        rst           = r;
        acc = v && exp_ready(occ, ordy, r) && !fl;
        @(posedge clk);
        if (r || fl) sb.delete();
        else if (acc) sb.push_back(mk(pc, ins, m));
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, ordy, 1'b0, a);
    endtask

    initial begin
        logic a;
        int   idx;
        logic [31:0] bp_pc [3];
        bp_pc[0] = 32'h300; bp_pc[1] = 32'h308; bp_pc[2] = 32'h310;

        // reset
        step(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b1, a);
        mon_en = 1'b1;
        step(1'b0, 32'h0, 64'h0, 2'b00, 1'b0, 1'b0, 1'b1, a);
        idle(1, 1'b1);

        // streaming
        step(1'b1, 32'h100, 64'hA1A1A1A1_A0A0A0A0, 2'b11, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 32'h108, 64'hB1B1B1B1_B0B0B0B0, 2'b11, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 32'h110, 64'hC1C1C1C1_C0C0C0C0, 2'b11, 1'b0, 1'b1, 1'b0, a);
        idle(2, 1'b1);

        // masking, including an all-zero mask
        step(1'b1, 32'h200, 64'hDEADBEEF_11111111, 2'b01, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 32'h204, 64'h22222222_33333333, 2'b10, 1'b0, 1'b1, 1'b0, a);
        step(1'b1, 32'h208, 64'h44444444_55555555, 2'b00, 1'b0, 1'b1, 1'b0, a);
        idle(2, 1'b1);

        // back-pressure: upstream holds each bundle until accepted
        idx = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            step(1'b1, bp_pc[idx], {32'h0BB00000 + bp_pc[idx], 32'h0AA00000 + bp_pc[idx]},
                 2'b11, 1'b0, (c >= 3), 1'b0, a);
            if (a) idx++;
        end
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL backpressure_accept: got %0d expected 3", idx);
        end
        idle(4, 1'b1);

        // flush while full (SKID with skid) with a concurrent input D
        step(1'b1, 32'h400, 64'h1, 2'b11, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 32'h408, 64'h2, 2'b11, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 32'h4D0, 64'hD, 2'b11, 1'b1, 1'b0, 1'b0, a);
        idle(3, 1'b1);

        // reset mid-stream, then flush+rst together, then flush right after reset
        step(1'b1, 32'h500, 64'h5, 2'b11, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 32'h508, 64'h6, 2'b11, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 32'h510, 64'h7, 2'b11, 1'b0, 1'b0, 1'b1, a);
        idle(1, 1'b1);
        step(1'b1, 32'h600, 64'h8, 2'b11, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 32'h608, 64'h9, 2'b11, 1'b1, 1'b0, 1'b1, a);
        step(1'b0, 32'h0, 64'h0, 2'b00, 1'b1, 1'b1, 1'b0, a);
        idle(2, 1'b1);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, {$urandom, $urandom},
                 2'($urandom_range(0, 3)), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, a);
        end
        idle(5, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
